// File: rtl/glitch_cmd_pkg.sv
// rtl/glitch_cmd_pkg.sv - opcodes, reply codes, payload lengths and FSM states for the command parser
package glitch_cmd_pkg;

    localparam logic [7:0] OP_DELAY  = 8'h64;
    localparam logic [7:0] OP_WIDTH  = 8'h77;
    localparam logic [7:0] OP_ARM    = 8'h67;
    localparam logic [7:0] OP_STATUS = 8'h73;

    localparam logic [7:0] REPLY_OK      = 8'h6B;
    localparam logic [7:0] REPLY_UNKNOWN = 8'h3F;
    localparam logic [7:0] REPLY_BUSY    = 8'h21;

    localparam logic [2:0] DELAY_LEN = 3'd4;
    localparam logic [2:0] WIDTH_LEN = 3'd2;

    // minimum number of cycles spent in RESP_WAIT after the send strobe
    localparam logic [1:0] RESP_GAP = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        RESP,
        RESP_WAIT
    } state_t;

endpackage

// File: rtl/glitch_cmd_parser_if.sv
// rtl/glitch_cmd_parser_if.sv - uart_rx / uart_tx byte handshake bundle for the command parser
interface glitch_cmd_parser_if;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic [7:0] tx_data_o;
    logic       tx_enable_o;
    logic       tx_busy_i;

    modport master (
        output rx_data_i,
        output rx_valid_i,
        output tx_busy_i,
        input  tx_data_o,
        input  tx_enable_o
    );

    modport slave (
        input  rx_data_i,
        input  rx_valid_i,
        input  tx_busy_i,
        output tx_data_o,
        output tx_enable_o
    );
endinterface

// File: rtl/cmd_timeout.sv
// rtl/cmd_timeout.sv - inter-byte timeout counter with expiry strobe, used only with CMD_TIMEOUT_EN
module cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [31:0] count_q;

    // a byte accepted in the same cycle wins over expiry
    assign expired = run && !clear && (count_q >= TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear || !run) begin
            count_q <= '0;
        end else if (!expired) begin
            count_q <= count_q + 32'd1;
        end
    end

endmodule

// File: rtl/glitch_cmd_parser.sv
// rtl/glitch_cmd_parser.sv - byte command decoder for glitch delay/width/arm/status; CMD_TIMEOUT_EN adds inter-byte timeout
module glitch_cmd_parser
    import glitch_cmd_pkg::*;
#(
    parameter logic [31:0] DEFAULT_DELAY  = 32'd0,
    parameter logic [15:0] DEFAULT_WIDTH  = 16'd1,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    glitch_cmd_parser_if.slave  uart,
    input  logic                glitch_busy_i,
    output logic [31:0]         delay_o,
    output logic [15:0]         width_o,
    output logic                arm_o
);

    state_t      state_q, state_d;
    logic [2:0]  pay_cnt_q, pay_cnt_d;
    logic        is_delay_q, is_delay_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] delay_d;
    logic [15:0] width_d;
    logic        arm_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d;
    logic        flag_q, flag_d;
    logic [1:0]  gap_q, gap_d;
    logic        byte_accept;
    logic        expired;

    assign uart.tx_data_o   = tx_data_q;
    assign uart.tx_enable_o = tx_en_q;

`ifdef CMD_TIMEOUT_EN
    cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (byte_accept),
        .run     (state_q == PAYLOAD),
        .expired (expired)
    );
    logic unused_bits;
    assign unused_bits = ^shadow_q[31:24];
`else
    assign expired = 1'b0;
    logic unused_bits;
    assign unused_bits = ^shadow_q[31:24] ^ byte_accept ^ (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d     = state_q;
        pay_cnt_d   = pay_cnt_q;
        is_delay_d  = is_delay_q;
        shadow_d    = shadow_q;
        delay_d     = delay_o;
        width_d     = width_o;
        arm_d       = 1'b0;
        tx_data_d   = tx_data_q;
        tx_en_d     = 1'b0;
        flag_d      = flag_q;
        gap_d       = gap_q;
        byte_accept = 1'b0;

        case (state_q)
            IDLE: begin
                if (uart.rx_valid_i) begin
                    byte_accept = 1'b1;
                    state_d     = RESP;
                    case (uart.rx_data_i)
                        OP_DELAY, OP_WIDTH: begin
                            is_delay_d = (uart.rx_data_i == OP_DELAY);
                            pay_cnt_d  = (uart.rx_data_i == OP_DELAY) ? DELAY_LEN : WIDTH_LEN;
                            shadow_d   = '0;
                            state_d    = PAYLOAD;
                        end
                        OP_ARM: begin
                            if (glitch_busy_i) begin
                                tx_data_d = REPLY_BUSY;
                            end else begin
                                arm_d     = 1'b1;
                                tx_data_d = REPLY_OK;
                            end
                        end
                        OP_STATUS: begin
                            tx_data_d = {6'b0, flag_q, glitch_busy_i};
                            flag_d    = 1'b0;
                        end
                        default: tx_data_d = REPLY_UNKNOWN;
                    endcase
                end
            end
            PAYLOAD: begin
                if (uart.rx_valid_i) begin
                    byte_accept = 1'b1;
                    shadow_d    = {shadow_q[23:0], uart.rx_data_i};
                    pay_cnt_d   = pay_cnt_q - 3'd1;
                    if (pay_cnt_q == 3'd1) begin
                        if (is_delay_q) delay_d = shadow_d;
                        else            width_d = shadow_d[15:0];
                        tx_data_d = REPLY_OK;
                        state_d   = RESP;
                    end
                end else if (expired) begin
                    // partial payload is abandoned silently; status reports it later
                    flag_d    = 1'b1;
                    pay_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            RESP: begin
                if (!uart.tx_busy_i) begin
                    tx_en_d = 1'b1;
                    gap_d   = '0;
                    state_d = RESP_WAIT;
                end
            end
            RESP_WAIT: begin
                // uart_tx may take a cycle or two to raise busy after the strobe
                if (gap_q != RESP_GAP) begin
                    gap_d = gap_q + 2'd1;
                end else if (!uart.tx_busy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pay_cnt_q  <= '0;
            is_delay_q <= 1'b0;
            shadow_q   <= '0;
            delay_o    <= DEFAULT_DELAY;
            width_o    <= DEFAULT_WIDTH;
            arm_o      <= 1'b0;
            tx_data_q  <= '0;
            tx_en_q    <= 1'b0;
            flag_q     <= 1'b0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            pay_cnt_q  <= pay_cnt_d;
            is_delay_q <= is_delay_d;
            shadow_q   <= shadow_d;
            delay_o    <= delay_d;
            width_o    <= width_d;
            arm_o      <= arm_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
            flag_q     <= flag_d;
            gap_q      <= gap_d;
        end
    end

endmodule

// File: tb/tb_glitch_cmd_parser.sv
// tb/tb_glitch_cmd_parser.sv - randomized self-checking bench for glitch_cmd_parser against a command-level model
module tb_glitch_cmd_parser;

    localparam int unsigned TO_CYCLES = 100;

    logic        clk;
    logic        rst_n;
    logic        glitch_busy;
    logic [31:0] delay;
    logic [15:0] width;
    logic        arm;

    glitch_cmd_parser_if bus();

    glitch_cmd_parser #(
        .DEFAULT_DELAY  (32'd0),
        .DEFAULT_WIDTH  (16'd1),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart          (bus),
        .glitch_busy_i (glitch_busy),
        .delay_o       (delay),
        .width_o       (width),
        .arm_o         (arm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // command-level reference state
    logic [31:0] model_delay;
    logic [15:0] model_width;
    logic        model_flag;
    int          model_arms;
    int          model_strobes;

    int strobe_cnt = 0;
    int arm_cnt    = 0;

    always @(negedge clk) begin
        if (bus.tx_enable_o) strobe_cnt++;
        if (arm) arm_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        model_delay = 32'd0;
        model_width = 16'd1;
        model_flag  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
    endtask

    // Sends a full command, checks config/arm one cycle after the last byte,
    // holds tx_busy for busy_pre cycles and checks the exact strobe cycle.
    task automatic do_cmd(input logic [7:0] cmd[$], input int busy_pre, input bit inject);
        logic [7:0] exp_reply;
        bit         exp_arm;
        int         s0, a0;
        exp_arm = 1'b0;
        case (cmd[0])
            8'h64: begin model_delay = {cmd[1], cmd[2], cmd[3], cmd[4]}; exp_reply = 8'h6B; end
            8'h77: begin model_width = {cmd[1], cmd[2]}; exp_reply = 8'h6B; end
            8'h67: begin
                exp_arm   = !glitch_busy;
                exp_reply = glitch_busy ? 8'h21 : 8'h6B;
            end
            8'h73: begin exp_reply = {6'b0, model_flag, glitch_busy}; model_flag = 1'b0; end
            default: exp_reply = 8'h3F;
        endcase
        s0 = strobe_cnt;
        a0 = arm_cnt;
        bus.tx_busy_i = (busy_pre > 0);
        foreach (cmd[i]) begin
            send_byte(cmd[i]);
            if (i < cmd.size() - 1) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        check("delay_after_cmd", delay, model_delay);
        check("width_after_cmd", width, {16'h0, model_width});
        check("arm_n_plus_1", {31'b0, arm}, {31'b0, exp_arm});
        check("tx_data_loaded", {24'b0, bus.tx_data_o}, {24'b0, exp_reply});
        if (inject && busy_pre == 0) begin
            bus.rx_data_i  = 8'h67;
            bus.rx_valid_i = 1'b1;
        end
        if (busy_pre > 0) begin
            repeat (busy_pre) @(negedge clk);
            check("tx_quiet_while_busy", strobe_cnt - s0, 0);
            bus.tx_busy_i = 1'b0;
        end
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
        check("tx_enable_timing", {31'b0, bus.tx_enable_o}, 32'd1);
        check("tx_data_at_strobe", {24'b0, bus.tx_data_o}, {24'b0, exp_reply});
        bus.tx_busy_i = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        bus.tx_busy_i = 1'b0;
        repeat (8) @(negedge clk);
        model_strobes++;
        if (exp_arm) model_arms++;
        check("strobe_count", strobe_cnt, model_strobes);
        check("arm_count", arm_cnt, model_arms);
        check("tx_data_stable", {24'b0, bus.tx_data_o}, {24'b0, exp_reply});
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] op;
        int         kind;

        rst_n          = 1'b0;
        bus.rx_data_i  = 8'h00;
        bus.rx_valid_i = 1'b0;
        bus.tx_busy_i  = 1'b0;
        glitch_busy    = 1'b0;
        model_reset();
        model_arms    = 0;
        model_strobes = 0;
        repeat (3) @(negedge clk);
        check("rst_delay", delay, 32'd0);
        check("rst_width", {16'h0, width}, 32'd1);
        check("rst_arm", {31'b0, arm}, 32'd0);
        check("rst_tx_enable", {31'b0, bus.tx_enable_o}, 32'd0);
        check("rst_tx_data", {24'b0, bus.tx_data_o}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        q = '{8'h64, 8'h00, 8'h00, 8'h01, 8'h2C};
        do_cmd(q, 0, 1'b0);
        check("delay_300", delay, 32'd300);
        q = '{8'h77, 8'h00, 8'h10};
        do_cmd(q, 0, 1'b1);
        check("width_16", {16'h0, width}, 32'd16);
        glitch_busy = 1'b0;
        q = '{8'h67};
        do_cmd(q, 0, 1'b0);
        glitch_busy = 1'b1;
        do_cmd(q, 0, 1'b0);
        glitch_busy = 1'b0;
        q = '{8'h41};
        do_cmd(q, 0, 1'b0);
        glitch_busy = 1'b1;
        q = '{8'h73};
        do_cmd(q, 1000, 1'b0);
        glitch_busy = 1'b0;

        for (int n = 0; n < 40; n++) begin
            glitch_busy = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 4);
            q.delete();
            case (kind)
                0: begin
                    q.push_back(8'h64);
                    repeat (4) q.push_back(8'($urandom));
                end
                1: begin
                    q.push_back(8'h77);
                    repeat (2) q.push_back(8'($urandom));
                end
                2: q.push_back(8'h67);
                3: q.push_back(8'h73);
                default: begin
                    do op = 8'($urandom);
                    while (op == 8'h64 || op == 8'h77 || op == 8'h67 || op == 8'h73);
                    q.push_back(op);
                end
            endcase
            do_cmd(q, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0,
                   1'($urandom_range(0, 1)));
        end
        glitch_busy = 1'b0;

`ifdef CMD_TIMEOUT_EN
        send_byte(8'h64);
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (TO_CYCLES + 5) @(negedge clk);
        model_flag = 1'b1;
        check("timeout_delay_kept", delay, model_delay);
        check("timeout_no_reply", strobe_cnt, model_strobes);
        q = '{8'h73};
        do_cmd(q, 0, 1'b0);
        do_cmd(q, 0, 1'b0);
`endif

        send_byte(8'h64);
        send_byte(8'h12);
        check("partial_payload_kept", delay, model_delay);
        rst_n = 1'b0;
        #1;
        check("midrst_delay", delay, 32'd0);
        check("midrst_width", {16'h0, width}, 32'd1);
        check("midrst_arm", {31'b0, arm}, 32'd0);
        check("midrst_tx_enable", {31'b0, bus.tx_enable_o}, 32'd0);
        check("midrst_tx_data", {24'b0, bus.tx_data_o}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        q = '{8'h64, 8'h00, 8'h00, 8'h00, 8'h05};
        do_cmd(q, 0, 1'b0);
        check("delay_5_after_reset", delay, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
